msg_char_writer: RTL and testbench

- Writer side of the on-screen text path: on request, fills one 8-entry line slot of the character-code buffer with a fixed message as 5-bit glyph codes, one code per clock.
- Glyph codes are the same character-ROM codes the glyph renderer reads back.
- Sits between the game-control FSM (issues `start`/`msg_id`/`stage`) and the character buffer write port.
- The renderer has read priority on that port. It stalls the writer through `wr_stall`.

---
 rtl/msg_char_writer_if.sv | 28 ++
 rtl/msg_char_writer.sv | 135 +++++++++++++
 tb/tb_msg_char_writer.sv | 201 ++++++++++++++++++++
 3 files changed

// File: rtl/msg_char_writer_if.sv
// Request and buffer-write signals of the message writer, bundled for port use.
// The slave side is the writer; the master side is the control FSM / buffer model.
interface msg_char_writer_if #(
  parameter int SLOT_W = 2,
  parameter int CODE_W = 5
);
  logic              start;
  logic [2:0]        msg_id;
  logic [1:0]        stage;
  logic [SLOT_W-1:0] slot;
  logic              wr_stall;
  logic              ready;
  logic              busy;
  logic              done;
  logic              buf_we;
  logic [SLOT_W+2:0] buf_waddr;
  logic [CODE_W-1:0] buf_wdata;

  modport master (
    output start, msg_id, stage, slot, wr_stall,
    input  ready, busy, done, buf_we, buf_waddr, buf_wdata
  );

  modport slave (
    input  start, msg_id, stage, slot, wr_stall,
    output ready, busy, done, buf_we, buf_waddr, buf_wdata
  );
endinterface

// File: rtl/msg_char_writer.sv
// Fills entries 0..6 of one character-buffer line slot with a fixed message,
// one glyph code per un-stalled cycle, then pulses done.
module msg_char_writer #(
  parameter int SLOT_W     = 2,
  parameter int CODE_W     = 5,
  parameter int BLANK_CODE = 19
) (
  input logic              clk,
  input logic              rst,
  msg_char_writer_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t            state_q;
  logic [2:0]        index_q;
  logic [2:0]        msg_q;
  logic [1:0]        stage_q;
  logic [SLOT_W-1:0] slot_q;
  logic              ready_q;
  logic              busy_q;
  logic              done_q;
  logic              we_q;
  logic [SLOT_W+2:0] waddr_q;
  logic [CODE_W-1:0] wdata_q;
  logic [CODE_W-1:0] wdata_d;
  logic [CODE_W-1:0] row_code [8];

  // Message table; ids 6 and 7 (CLEAR / reserved) fall through to all blanks.
  function automatic logic [CODE_W-1:0] glyph(input logic [2:0] m,
                                              input logic [2:0] i,
                                              input logic [1:0] s);
    int v;
    v = BLANK_CODE;
    case (m)
      3'd0: case (i)
        3'd0: v = 6;  3'd1: v = 11; 3'd2: v = 17; 3'd3: v = 11;
        3'd4: v = 13; 3'd6: v = int'(s); default: v = BLANK_CODE;
      endcase
      3'd1: case (i)
        3'd2: v = 8;  3'd3: v = 12; 3'd4: v = 14; default: v = BLANK_CODE;
      endcase
      3'd2: case (i)
        3'd1: v = 6;  3'd2: v = 25; 3'd3: v = 26; 3'd4: v = 11;
        default: v = BLANK_CODE;
      endcase
      3'd3: case (i)
        3'd1: v = 14; 3'd2: v = 11; 3'd3: v = 20; 3'd4: v = 16;
        default: v = BLANK_CODE;
      endcase
      3'd4: case (i)
        3'd1: v = 15; 3'd2: v = 11; 3'd3: v = 16; 3'd4: v = 15;
        3'd5: v = 18; default: v = BLANK_CODE;
      endcase
      3'd5: case (i)
        3'd0: v = 15; 3'd1: v = 11; 3'd2: v = 16; 3'd3: v = 15;
        3'd4: v = 9;  3'd5: v = 10; 3'd6: v = 16; default: v = BLANK_CODE;
      endcase
      default: v = BLANK_CODE;
    endcase
    return CODE_W'(v);
  endfunction

  for (genvar gi = 0; gi < 8; gi++) begin : g_row
    assign row_code[gi] = glyph(msg_q, 3'(gi), stage_q);
  end

  assign wdata_d = row_code[index_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      index_q <= 3'd0;
      msg_q   <= 3'd0;
      stage_q <= 2'd0;
      slot_q  <= '0;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      we_q    <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          done_q  <= 1'b0;
          we_q    <= 1'b0;
          ready_q <= 1'b1;
          busy_q  <= 1'b0;
          if (bus.start && ready_q) begin
            msg_q   <= bus.msg_id;
            stage_q <= bus.stage;
            slot_q  <= bus.slot;
            index_q <= 3'd0;
            ready_q <= 1'b0;
            busy_q  <= 1'b1;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          // A stalled cycle keeps address/data as they were so the bus stays quiet.
          if (!bus.wr_stall) begin
            we_q    <= 1'b1;
            waddr_q <= {slot_q, index_q};
            wdata_q <= wdata_d;
            index_q <= index_q + 3'd1;
            if (index_q == 3'd6) begin
              state_q <= DONE;
            end
          end else begin
            we_q <= 1'b0;
          end
        end
        DONE: begin
          we_q    <= 1'b0;
          done_q  <= 1'b1;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign bus.ready     = ready_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.buf_we    = we_q;
  assign bus.buf_waddr = waddr_q;
  assign bus.buf_wdata = wdata_q;

endmodule

// File: tb/tb_msg_char_writer.sv
// Randomized scoreboard bench for msg_char_writer: the driver predicts every
// write (edge number, address, code) and every done pulse; a monitor checks them.
module tb_msg_char_writer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  typedef struct {
    int cyc;
    int addr;
    int data;
  } wr_t;

  wr_t wq[$];
  int  dq[$];

  int msg_tbl [6][7] = '{
    '{6, 11, 17, 11, 13, 19, 0},
    '{19, 19, 8, 12, 14, 19, 19},
    '{19, 6, 25, 26, 11, 19, 19},
    '{19, 14, 11, 20, 16, 19, 19},
    '{19, 15, 11, 16, 15, 18, 19},
    '{15, 11, 16, 15, 9, 10, 16}
  };

  msg_char_writer_if #(.SLOT_W(2), .CODE_W(5)) bus ();

  msg_char_writer #(.SLOT_W(2), .CODE_W(5), .BLANK_CODE(19)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (edge %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int ref_code(input int m, input int i, input int s);
    if (m >= 6) return 19;
    if (m == 0 && i == 6) return s;
    return msg_tbl[m][i];
  endfunction

  // Monitor: outputs settle after posedge, sampled on the falling edge.
  always @(negedge clk) begin
    if (bus.buf_we) begin
      if (wq.size() == 0) begin
        check("unexpected_write", 1, 0);
      end else begin
        wr_t w;
        w = wq.pop_front();
        check("write_edge", cyc, w.cyc);
        check("write_addr", int'(bus.buf_waddr), w.addr);
        check("write_data", int'(bus.buf_wdata), w.data);
        $display("write edge=%0d addr=%0d data=%0d", cyc, bus.buf_waddr, bus.buf_wdata);
      end
    end
    if (bus.done) begin
      if (dq.size() == 0) begin
        check("unexpected_done", 1, 0);
      end else begin
        check("done_edge", cyc, dq.pop_front());
      end
    end
  end

  task automatic wait_ready();
    for (int k = 0; k < 40; k++) begin
      if (bus.ready) return;
      @(negedge clk);
    end
    check("ready_timeout", int'(bus.ready), 1);
  endtask

  // One request; stall_pct random stalls, two forced stalls once fst writes
  // are done, spurious starts while busy, input scrambling, optional reset abort.
  task automatic run_seq(input int m, input int s, input int sl, input int stall_pct,
                         input int fst, input bit spur, input bit scram, input int abort_at);
    int n_acc;
    int nw;
    int e;
    int forced;
    bit st;
    wait_ready();
    bus.start  = 1'b1;
    bus.msg_id = 3'(m);
    bus.stage  = 2'(s);
    bus.slot   = 2'(sl);
    bus.wr_stall = 1'b0;
    n_acc  = cyc + 1;
    nw     = 0;
    e      = n_acc;
    forced = 0;
    @(negedge clk);
    bus.start = 1'b0;
    if (scram) begin
      bus.msg_id = 3'($urandom_range(7));
      bus.stage  = 2'($urandom_range(3));
      bus.slot   = 2'($urandom_range(3));
    end
    while (nw < 7) begin
      if (abort_at >= 0 && nw == abort_at) begin
        rst = 1'b1;
        bus.wr_stall = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        check("abort_we", int'(bus.buf_we), 0);
        check("abort_ready", int'(bus.ready), 1);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_done", int'(bus.done), 0);
        $display("abort msg=%0d after %0d writes", m, nw);
        repeat (3) @(negedge clk);
        return;
      end
      st = ($urandom_range(99) < stall_pct);
      if (nw == fst && forced < 2) begin
        st = 1'b1;
        forced++;
      end
      bus.wr_stall = st;
      bus.start = spur && ($urandom_range(2) == 0);
      if (!st) begin
        wq.push_back('{cyc: e + 1, addr: sl * 8 + nw, data: ref_code(m, nw, s)});
        nw++;
      end
      e++;
      @(negedge clk);
      check("busy_in_seq", int'(bus.busy), 1);
      check("ready_in_seq", int'(bus.ready), 0);
    end
    bus.start = 1'b0;
    bus.wr_stall = 1'b0;
    dq.push_back(e + 1);
    while (cyc < e + 2) @(negedge clk);
    check("ready_after", int'(bus.ready), 1);
    check("busy_after", int'(bus.busy), 0);
    $display("seq msg=%0d stage=%0d slot=%0d accepted=%0d done_expected=%0d", m, s, sl, n_acc, e + 1);
  endtask

  initial begin
    bus.start = 1'b0;
    bus.msg_id = 3'd0;
    bus.stage = 2'd0;
    bus.slot = 2'd0;
    bus.wr_stall = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check("rst_ready", int'(bus.ready), 1);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_we", int'(bus.buf_we), 0);
    check("rst_waddr", int'(bus.buf_waddr), 0);
    check("rst_wdata", int'(bus.buf_wdata), 0);
    rst = 1'b0;
    @(negedge clk);

    run_seq(0, 2, 1, 0, -1, 1'b0, 1'b0, -1);
    run_seq(2, 0, 3, 0, 3, 1'b0, 1'b0, -1);
    run_seq(3, 1, 2, 0, -1, 1'b1, 1'b0, -1);
    run_seq(5, 3, 0, 0, -1, 1'b0, 1'b1, -1);
    run_seq(4, 0, 2, 0, -1, 1'b0, 1'b0, 3);
    run_seq(7, 0, 1, 0, -1, 1'b0, 1'b0, -1);
    run_seq(3, 0, 2, 0, -1, 1'b0, 1'b0, -1);
    run_seq(1, 0, 2, 0, -1, 1'b0, 1'b0, -1);

    // start together with reset must be lost
    wait_ready();
    rst = 1'b1;
    bus.start = 1'b1;
    bus.msg_id = 3'd1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_busy", int'(bus.busy), 0);
    check("rst_start_ready", int'(bus.ready), 1);
    $display("start with reset dropped");

    for (int t = 0; t < 14; t++) begin
      run_seq($urandom_range(7), $urandom_range(3), $urandom_range(3), 30, -1,
              1'($urandom_range(1)), 1'($urandom_range(1)), -1);
    end

    repeat (10) @(negedge clk);
    check("writes_pending", wq.size(), 0);
    check("dones_pending", dq.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
